// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings, the JAL opcode
// and the saturating counter update.
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  function automatic logic [1:0] ctr_sat(input logic [1:0] ctr, input logic taken);
    if (taken)
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'b01;
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Tagged table of 2-bit counters: async lookup port, sync read-modify-write
// resolve port that trains on a hit and allocates on a miss.
module bp_table
  import bp_pkg::*;
#(
  parameter int         IDX_W    = 7,
  parameter int         TAG_W    = 23,
  parameter logic [1:0] INIT_CTR = CTR_WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_hit,
  output logic [1:0]       lk_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_taken
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic             valid_q [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [1:0]       ctr_q   [DEPTH];
  logic             wr_hit;

  always_comb begin
    lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_ctr = ctr_q[lk_idx];
    wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= INIT_CTR;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_sat(ctr_q[wr_idx], wr_taken);
      end else begin
        valid_q[wr_idx] <= 1'b1;
        ctr_q[wr_idx]   <= wr_taken ? CTR_WT : CTR_WNT;
      end
    end
  end

  // Tags need no reset: an entry is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && !wr_hit)
      tag_q[wr_idx] <= wr_tag;
  end

endmodule

// File: rtl/bp_gshare.sv
// Fetch-stage gshare/bimodal branch predictor: combinational lookup, resolve-time
// training, speculative GHR with mispredict repair, and mispredict statistics.
module bp_gshare
  import bp_pkg::*;
#(
  parameter int         IDX_W    = 7,
  parameter int         TAG_W    = 23,
  parameter int         HIST_W   = 0,
  parameter logic [1:0] INIT_CTR = CTR_WNT
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 rdy_in,
  input  logic                                 lk_valid,
  input  logic                                 lk_is_jal,
  input  logic [31:0]                          lk_pc,
  input  logic [31:0]                          lk_imm,
  output logic                                 pred_taken,
  output logic [31:0]                          pred_target,
  output logic [((HIST_W > 0) ? HIST_W : 1)-1:0] pred_ghr,
  input  logic                                 rs_valid,
  input  logic [31:0]                          rs_pc,
  input  logic                                 rs_taken,
  input  logic                                 rs_pred_taken,
  input  logic [31:0]                          rs_target,
  input  logic [((HIST_W > 0) ? HIST_W : 1)-1:0] rs_ghr,
  output logic                                 predict_fail,
  output logic [31:0]                          fail_pc,
  output logic [31:0]                          stat_branches,
  output logic [31:0]                          stat_misses
);

  localparam int GW = (HIST_W > 0) ? HIST_W : 1;

  logic [GW-1:0]    ghr_q;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] rs_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] rs_tag;
  logic             lk_hit;
  logic [1:0]       lk_ctr;
  logic             lk_fire;
  logic             rs_fire;
  logic             mispredict;

  always_comb begin
    lk_idx     = lk_pc[IDX_W+1:2] ^ ((HIST_W > 0) ? IDX_W'(ghr_q) : '0);
    rs_idx     = rs_pc[IDX_W+1:2] ^ ((HIST_W > 0) ? IDX_W'(rs_ghr) : '0);
    lk_tag     = lk_pc[IDX_W+1+TAG_W:IDX_W+2];
    rs_tag     = rs_pc[IDX_W+1+TAG_W:IDX_W+2];
    lk_fire    = rdy_in && lk_valid;
    rs_fire    = rdy_in && rs_valid;
    mispredict = rs_fire && (rs_taken != rs_pred_taken);
    pred_taken = lk_fire && (lk_is_jal || (lk_hit && lk_ctr[1]));
    pred_target = '0;
    if (lk_fire)
      pred_target = pred_taken ? lk_pc + lk_imm : lk_pc + 32'd4;
    pred_ghr = ghr_q;
  end

  bp_table #(
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .INIT_CTR (INIT_CTR)
  ) u_table (
    .clk      (clk_in),
    .rst      (rst_in),
    .lk_idx   (lk_idx),
    .lk_tag   (lk_tag),
    .lk_hit   (lk_hit),
    .lk_ctr   (lk_ctr),
    .wr_en    (rs_fire),
    .wr_idx   (rs_idx),
    .wr_tag   (rs_tag),
    .wr_taken (rs_taken)
  );

  // Repair beats the speculative shift: a lookup alongside a mispredict is wrong-path.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      ghr_q <= '0;
    else if (HIST_W > 0) begin
      if (mispredict)
        ghr_q <= GW'({rs_ghr, rs_taken});
      else if (lk_fire && !lk_is_jal)
        ghr_q <= GW'({ghr_q, pred_taken});
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      predict_fail  <= 1'b0;
      fail_pc       <= '0;
      stat_branches <= '0;
      stat_misses   <= '0;
    end else if (rs_fire) begin
      predict_fail  <= mispredict;
      stat_branches <= stat_branches + 32'd1;
      if (mispredict) begin
        fail_pc     <= rs_taken ? rs_target : rs_pc + 32'd4;
        stat_misses <= stat_misses + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_bp_gshare.sv
// Self-checking bench: a bimodal instance against a behavioural table model,
// plus a 4-bit-history instance for GHR shift/repair scenarios.
module tb_bp_gshare;

  logic        clk = 1'b0;
  logic        rst, rdy, lk_valid, lk_is_jal, rs_valid, rs_taken, rs_pred_taken;
  logic [31:0] lk_pc, lk_imm, rs_pc, rs_target;
  logic [0:0]  rs_ghr_a;
  logic [3:0]  rs_ghr_b;

  logic        a_pred_taken, a_predict_fail;
  logic [31:0] a_pred_target, a_fail_pc, a_stat_br, a_stat_miss;
  logic [0:0]  a_pred_ghr;
  logic        b_pred_taken, b_predict_fail;
  logic [31:0] b_pred_target, b_fail_pc, b_stat_br, b_stat_miss;
  logic [3:0]  b_pred_ghr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_gshare #(.IDX_W(7), .TAG_W(23), .HIST_W(0), .INIT_CTR(2'b01)) dut_a (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .lk_valid(lk_valid), .lk_is_jal(lk_is_jal),
    .lk_pc(lk_pc), .lk_imm(lk_imm), .pred_taken(a_pred_taken), .pred_target(a_pred_target),
    .pred_ghr(a_pred_ghr), .rs_valid(rs_valid), .rs_pc(rs_pc), .rs_taken(rs_taken),
    .rs_pred_taken(rs_pred_taken), .rs_target(rs_target), .rs_ghr(rs_ghr_a),
    .predict_fail(a_predict_fail), .fail_pc(a_fail_pc), .stat_branches(a_stat_br),
    .stat_misses(a_stat_miss)
  );

  bp_gshare #(.IDX_W(7), .TAG_W(23), .HIST_W(4), .INIT_CTR(2'b01)) dut_b (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .lk_valid(lk_valid), .lk_is_jal(lk_is_jal),
    .lk_pc(lk_pc), .lk_imm(lk_imm), .pred_taken(b_pred_taken), .pred_target(b_pred_target),
    .pred_ghr(b_pred_ghr), .rs_valid(rs_valid), .rs_pc(rs_pc), .rs_taken(rs_taken),
    .rs_pred_taken(rs_pred_taken), .rs_target(rs_target), .rs_ghr(rs_ghr_b),
    .predict_fail(b_predict_fail), .fail_pc(b_fail_pc), .stat_branches(b_stat_br),
    .stat_misses(b_stat_miss)
  );

  // Reference model of the bimodal instance: 128 entries, tag = pc >> 9.
  bit          m_valid [128];
  int unsigned m_tag   [128];
  int          m_ctr   [128];
  bit          m_fail;
  logic [31:0] m_fail_pc, m_br, m_miss;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % 128;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> 9;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_fail = 1'b0; m_fail_pc = '0; m_br = '0; m_miss = '0;
  endtask

  task automatic model_lookup(output bit t, output logic [31:0] tg);
    int unsigned i;
    t = 1'b0; tg = '0;
    if (rdy && lk_valid) begin
      i = idx_of(lk_pc);
      t = lk_is_jal || (m_valid[i] && m_tag[i] == tag_of(lk_pc) && m_ctr[i] >= 2);
      tg = t ? lk_pc + lk_imm : lk_pc + 32'd4;
    end
  endtask

  task automatic model_edge();
    int unsigned i;
    bit mis;
    if (rst) model_reset();
    else if (rdy && rs_valid) begin
      i = idx_of(rs_pc);
      if (m_valid[i] && m_tag[i] == tag_of(rs_pc))
        m_ctr[i] = rs_taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                            : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
      else begin
        m_valid[i] = 1'b1; m_tag[i] = tag_of(rs_pc); m_ctr[i] = rs_taken ? 2 : 1;
      end
      mis = (rs_taken != rs_pred_taken);
      m_fail = mis;
      if (mis) m_fail_pc = rs_taken ? rs_target : rs_pc + 32'd4;
      m_br = m_br + 1;
      m_miss = m_miss + 32'(mis);
    end
  endtask

  // One clock: check lookup outputs, take the edge, check registered outputs.
  task automatic cycle();
    bit et;
    logic [31:0] etg;
    #1;
    model_lookup(et, etg);
    check("pred_taken", 32'(a_pred_taken), 32'(et));
    check("pred_target", a_pred_target, etg);
    check("pred_ghr_bimodal", 32'(a_pred_ghr), 32'd0);
    @(posedge clk);
    model_edge();
    #1;
    check("predict_fail", 32'(a_predict_fail), 32'(m_fail));
    check("fail_pc", a_fail_pc, m_fail_pc);
    check("stat_branches", a_stat_br, m_br);
    check("stat_misses", a_stat_miss, m_miss);
  endtask

  task automatic idle();
    lk_valid = 1'b0; lk_is_jal = 1'b0; rs_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [31:0] imm, input bit jal);
    lk_valid = 1'b1; lk_is_jal = jal; lk_pc = pc; lk_imm = imm;
  endtask

  task automatic resolve(input logic [31:0] pc, input bit t, input bit p, input logic [31:0] tgt);
    rs_valid = 1'b1; rs_pc = pc; rs_taken = t; rs_pred_taken = p; rs_target = tgt;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; idle();
    lk_pc = '0; lk_imm = '0; rs_pc = '0; rs_taken = 1'b0; rs_pred_taken = 1'b0;
    rs_target = '0; rs_ghr_a = '0; rs_ghr_b = '0;
    model_reset();
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    check("reset_fail", 32'(a_predict_fail), 32'd0);
    check("reset_stats", a_stat_br, 32'd0);

    // Cold lookup misses and predicts fall-through.
    lookup(32'h100, 32'h20, 1'b0);
    #1;
    check("cold_taken", 32'(a_pred_taken), 32'd0);
    check("cold_target", a_pred_target, 32'h104);
    cycle();

    // First taken resolve allocates WT and mispredicts.
    idle(); resolve(32'h100, 1'b1, 1'b0, 32'h120); cycle();
    check("alloc_fail", 32'(a_predict_fail), 32'd1);
    check("alloc_fail_pc", a_fail_pc, 32'h120);
    check("alloc_misses", a_stat_miss, 32'd1);
    idle(); lookup(32'h100, 32'h20, 1'b0);
    #1;
    check("relookup_taken", 32'(a_pred_taken), 32'd1);
    check("relookup_target", a_pred_target, 32'h120);
    cycle();
    idle(); resolve(32'h100, 1'b1, 1'b1, 32'h120); cycle();
    check("correct_no_fail", 32'(a_predict_fail), 32'd0);

    // ST down to SNT with saturation, checking each lookup in between.
    for (int k = 0; k < 4; k++) begin
      idle(); resolve(32'h100, 1'b0, (k < 2), 32'h120); cycle();
      idle(); lookup(32'h100, 32'h20, 1'b0); cycle();
    end

    // Train back to ST, then alias at 0x300 (same index, different tag).
    for (int k = 0; k < 3; k++) begin
      idle(); resolve(32'h100, 1'b1, 1'b1, 32'h120); cycle();
    end
    idle(); lookup(32'h300, 32'h40, 1'b0);
    #1;
    check("alias_lookup", 32'(a_pred_taken), 32'd0);
    cycle();
    idle(); resolve(32'h300, 1'b0, 1'b0, 32'h340); cycle();
    idle(); lookup(32'h100, 32'h20, 1'b0);
    #1;
    check("evicted_lookup", 32'(a_pred_taken), 32'd0);
    cycle();
    idle(); resolve(32'h300, 1'b1, 1'b0, 32'h340); cycle();

    // Same-entry lookup and resolve: lookup sees the pre-update counter.
    idle(); lookup(32'h300, 32'h40, 1'b0); resolve(32'h300, 1'b0, 1'b1, 32'h340);
    #1;
    check("rbw_old_value", 32'(a_pred_taken), 32'd1);
    cycle();
    idle(); lookup(32'h300, 32'h40, 1'b0); cycle();

    // JAL is always taken with a negative offset.
    idle(); lookup(32'h200, 32'hFFFF_FFF8, 1'b1);
    #1;
    check("jal_target", a_pred_target, 32'h1F8);
    cycle();

    // Stall: nothing moves, lookup outputs forced low.
    rdy = 1'b0; idle(); lookup(32'h300, 32'h40, 1'b0); resolve(32'h300, 1'b1, 1'b0, 32'h340);
    cycle(); cycle();
    rdy = 1'b1; idle(); cycle();

    // History instance: build GHR T,NT,T then repair over a concurrent lookup.
    rst = 1'b1; cycle(); rst = 1'b0;
    idle(); resolve(32'h100, 1'b1, 1'b1, 32'h120); rs_ghr_b = 4'b0000; cycle();
    idle(); resolve(32'h100, 1'b1, 1'b1, 32'h120); rs_ghr_b = 4'b0010; cycle();
    check("b_ghr_after_correct", 32'(b_pred_ghr), 32'd0);
    begin
      logic [3:0] exp_ghr [3];
      bit         exp_t   [3];
      exp_ghr = '{4'b0000, 4'b0001, 4'b0010};
      exp_t   = '{1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
        idle(); lookup(32'h100, 32'h20, 1'b0);
        #1;
        check("b_hist_taken", 32'(b_pred_taken), 32'(exp_t[k]));
        check("b_hist_ghr", 32'(b_pred_ghr), 32'(exp_ghr[k]));
        cycle();
      end
    end
    check("b_ghr_0101", 32'(b_pred_ghr), 32'h5);
    idle(); lookup(32'h200, 32'hFFFF_FFF8, 1'b1); cycle();
    check("b_ghr_jal_hold", 32'(b_pred_ghr), 32'h5);
    idle(); lookup(32'h100, 32'h20, 1'b0); resolve(32'h500, 1'b1, 1'b0, 32'h540);
    rs_ghr_b = 4'b0001; cycle();
    check("b_ghr_repair", 32'(b_pred_ghr), 32'h3);
    check("b_repair_fail", 32'(b_predict_fail), 32'd1);
    check("b_repair_fail_pc", b_fail_pc, 32'h540);
    rdy = 1'b0; idle(); lookup(32'h100, 32'h20, 1'b0); cycle();
    check("b_ghr_stall", 32'(b_pred_ghr), 32'h3);
    rdy = 1'b1; rs_ghr_b = '0;

    // Randomised traffic on a small PC pool to force hits, aliases and evictions.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pool [6];
      pool = '{32'h100, 32'h300, 32'h104, 32'h8100, 32'h1F0, 32'hFFFF_FFFC};
      idle();
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0)
        lookup(pool[$urandom_range(0, 5)], $urandom, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 1) != 0)
        resolve(pool[$urandom_range(0, 5)], 1'($urandom), 1'($urandom), $urandom);
      rs_ghr_a = 1'($urandom);
      cycle();
    end
    rst = 1'b0; rdy = 1'b1; idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
